// File: rtl/if_stage_if.sv
// Byte-wide memory-controller port used by the instruction-fetch stage.
// The fetch stage is the master: it issues byte-read requests and addresses,
// the memory controller answers with busy/ack and the data byte.
interface if_stage_if #(
   parameter int MEM_ADDR_W = 32
);
   logic                  mem_req_out;
   logic [MEM_ADDR_W-1:0] mem_addr_out;
   logic                  mem_busy_in;
   logic                  mem_ack_in;
   logic [7:0]            mem_byte_in;

   modport master (
      output mem_req_out,
      output mem_addr_out,
      input  mem_busy_in,
      input  mem_ack_in,
      input  mem_byte_in
   );

   modport slave (
      input  mem_req_out,
      input  mem_addr_out,
      output mem_busy_in,
      output mem_ack_in,
      output mem_byte_in
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Holds the PC, fetches each 32-bit instruction as
// four little-endian bytes over the byte-wide memory port, asks the pipeline
// controller to stall until a whole instruction is assembled, and redirects
// on a taken branch from EX.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          MEM_ADDR_W = 32
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [5:0]  stall,
   input  logic        branch_flag_in,
   input  logic [31:0] branch_target,
   if_stage_if.master  mem,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stallreq_if
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [1:0]  cnt, cnt_nx;
   logic [7:0]  b0, b1, b2;
   logic [7:0]  b0_nx, b1_nx, b2_nx;
   logic        req, req_nx;
   logic [31:0] if_pc_nx, if_inst_nx;
   logic        ack_ok;
   logic [31:0] addr_sum;
   logic        unused_stall;

   // Only stall[1] concerns this stage; the other controller bits are ignored.
   assign unused_stall = ^{stall[5:2], stall[0]};

   // An ack means something only while a request is actually outstanding.
   assign ack_ok = req & mem.mem_ack_in;

   // Byte address walks through the word; 32-bit sum wraps naturally.
   assign addr_sum         = pc + {30'd0, cnt};
   assign mem.mem_addr_out = MEM_ADDR_W'(addr_sum);
   assign mem.mem_req_out  = req;

   // An instruction is ready only while it is being presented in DONE.
   assign stallreq_if = (state != DONE);

   // Next-state, PC, byte-buffer and request decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      state_nx   = state;
      pc_nx      = pc;
      cnt_nx     = cnt;
      b0_nx      = b0;
      b1_nx      = b1;
      b2_nx      = b2;
      if_pc_nx   = if_pc;
      if_inst_nx = if_inst;

      case (state)
         IDLE: begin
            if (!mem.mem_busy_in) state_nx = FETCH;
         end
         FETCH: begin
            if (ack_ok) begin
               case (cnt)
                  2'd0: b0_nx = mem.mem_byte_in;
                  2'd1: b1_nx = mem.mem_byte_in;
                  2'd2: b2_nx = mem.mem_byte_in;
                  default: begin
                     if_inst_nx = {mem.mem_byte_in, b2, b1, b0};
                     if_pc_nx   = pc;
                     state_nx   = DONE;
                  end
               endcase
               cnt_nx = cnt + 2'd1;
            end else if (mem.mem_busy_in && cnt == 2'd0) begin
               state_nx = IDLE;
            end
         end
         DONE: begin
            if (!stall[1]) begin
               pc_nx    = pc + 32'd4;
               cnt_nx   = 2'd0;
               state_nx = FETCH;
            end
         end
         default: state_nx = FETCH;
      endcase

      // A redirect overrides everything above, including a completing fetch.
      if (branch_flag_in) begin
         pc_nx      = branch_target & ~32'h3;
         cnt_nx     = 2'd0;
         state_nx   = FETCH;
         if_pc_nx   = if_pc;
         if_inst_nx = if_inst;
      end

      // Request only while fetching and the port was free; a redirect costs one gap cycle.
      req_nx = (state_nx == FETCH) && !mem.mem_busy_in && !branch_flag_in;
   end

   // Control state, PC, request and presented instruction registers.
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!rst_in) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         cnt     <= 2'd0;
         req     <= 1'b0;
         if_pc   <= 32'd0;
         if_inst <= 32'd0;
      end else begin
         state   <= state_nx;
         pc      <= pc_nx;
         cnt     <= cnt_nx;
         req     <= req_nx;
         if_pc   <= if_pc_nx;
         if_inst <= if_inst_nx;
      end
   end

   // Byte buffer for the first three bytes of the word being fetched.
   always_ff @(posedge clk_in) begin
      // NOTE: the buffer has no reset; each byte is rewritten before it is ever assembled.
      b0 <= b0_nx;
      b1 <= b1_nx;
      b2 <= b2_nx;
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// stimulus, all checked every cycle against a transaction-level model that
// collects fetched bytes in a queue.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [5:0]  stall;
   logic        branch_flag_in;
   logic [31:0] branch_target;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq_if;

   if_stage_if #(.MEM_ADDR_W(32)) mem ();

   if_stage #(.RESET_PC(RESET_PC), .MEM_ADDR_W(32)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .stall          (stall),
      .branch_flag_in (branch_flag_in),
      .branch_target  (branch_target),
      .mem            (mem),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .stallreq_if    (stallreq_if)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic        m_known = 1'b0;
   logic [31:0] m_pc;
   logic [7:0]  m_got[$];
   logic        m_ready;
   logic        m_req;
   logic [31:0] m_ipc;
   logic [31:0] m_inst;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Memory contents: the first word is the instruction 32'h0050_0013.
   function automatic logic [7:0] byte_at(input logic [31:0] a);
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h00;
         32'd2:   return 8'h50;
         32'd3:   return 8'h00;
         default: return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
   endfunction

   // Model: collect bytes until four are in hand, then present the word.
   task automatic model_step(input logic r, input logic s1, input logic br,
                             input logic [31:0] tgt, input logic bz, input logic ak);
      if (!r) begin
         m_pc = RESET_PC; m_got.delete(); m_ready = 1'b0; m_req = 1'b0;
         m_ipc = 32'd0; m_inst = 32'd0; m_known = 1'b1;
      end else if (br) begin
         m_pc = tgt & ~32'h3; m_got.delete(); m_ready = 1'b0; m_req = 1'b0;
      end else if (m_ready) begin
         if (!s1) begin
            m_pc = m_pc + 32'd4; m_ready = 1'b0; m_req = !bz;
         end else begin
            m_req = 1'b0;
         end
      end else begin
         if (m_req && ak) m_got.push_back(byte_at(m_pc + 32'(m_got.size())));
         if (m_got.size() == 4) begin
            m_inst  = {m_got[3], m_got[2], m_got[1], m_got[0]};
            m_ipc   = m_pc;
            m_ready = 1'b1;
            m_req   = 1'b0;
            m_got.delete();
         end else begin
            m_req = !bz;
         end
      end
   endtask

   // One clock cycle: check current outputs, drive inputs, advance model, clock.
   task automatic cycle(input logic r, input logic s1, input logic br,
                        input logic [31:0] tgt, input logic bz, input logic ak);
      logic [31:0] dut_addr;
      if (m_known) begin
         check("req", 32'(mem.mem_req_out), 32'(m_req));
         check("stallreq", 32'(stallreq_if), 32'(!m_ready));
         check("if_pc", if_pc, m_ipc);
         check("if_inst", if_inst, m_inst);
         if (m_req) check("addr", mem.mem_addr_out, m_pc + 32'(m_got.size()));
      end
      dut_addr           = mem.mem_addr_out;
      rst_in             = r;
      stall              = 6'($urandom);
      stall[1]           = s1;
      branch_flag_in     = br;
      branch_target      = tgt;
      mem.mem_busy_in    = bz;
      mem.mem_ack_in     = ak;
      mem.mem_byte_in    = byte_at(dut_addr);
      model_step(r, s1, br, tgt, bz, ak);
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   initial begin
      rst_in = 1'b0; stall = 6'd0; branch_flag_in = 1'b0; branch_target = 32'd0;
      mem.mem_busy_in = 1'b0; mem.mem_ack_in = 1'b0; mem.mem_byte_in = 8'd0;
      @(negedge clk_in);

      // Reset, then acks every cycle: bytes from addresses 0..3.
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("rst_req", 32'(mem.mem_req_out), 32'd0);
      check("rst_stallreq", 32'(stallreq_if), 32'd1);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_inst", if_inst, 32'd0);
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("t1_inst", if_inst, 32'h0050_0013);
      check("t1_pc", if_pc, 32'd0);
      check("t1_stallreq", 32'(stallreq_if), 32'd0);

      // Held in DONE by stall[1], then consumed: next request at 4.
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("t2_hold_req", 32'(mem.mem_req_out), 32'd0);
      check("t2_hold_inst", if_inst, 32'h0050_0013);
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      check("t2_req", 32'(mem.mem_req_out), 32'd1);
      check("t2_addr", mem.mem_addr_out, 32'd4);

      // Two bytes, then busy for five cycles, then resume at pc+2.
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      check("t3_busy_req", 32'(mem.mem_req_out), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      check("t3_resume_addr", mem.mem_addr_out, 32'd6);
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("t3_inst", if_inst, word_at(32'd4));
      check("t3_pc", if_pc, 32'd4);

      // Branch to 0x1002 at cnt=2 with an ack present: byte dropped, one gap.
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_1002, 1'b0, 1'b1);
      check("t4_gap_req", 32'(mem.mem_req_out), 32'd0);
      check("t4_keep_pc", if_pc, 32'd4);
      check("t4_stallreq", 32'(stallreq_if), 32'd1);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      check("t4_addr", mem.mem_addr_out, 32'h0000_1000);
      repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("t4_if_pc", if_pc, 32'h0000_1000);
      check("t4_inst", if_inst, word_at(32'h0000_1000));

      // Branch in the same cycle as a DONE consume: target wins over pc+4.
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      check("t5_addr", mem.mem_addr_out, 32'h0000_2000);

      // Reset mid-fetch: outputs back to reset values, refetch from RESET_PC.
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("t6_req", 32'(mem.mem_req_out), 32'd0);
      check("t6_if_pc", if_pc, 32'd0);
      check("t6_if_inst", if_inst, 32'd0);
      check("t6_stallreq", 32'(stallreq_if), 32'd1);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      check("t6_addr", mem.mem_addr_out, RESET_PC);

      // Random traffic, including branches near the top of the address space.
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] tgt;
         case ($urandom_range(0, 2))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: tgt = 32'($urandom_range(0, 255));
         endcase
         cycle($urandom_range(0, 199) != 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 99) < 4,
               tgt,
               $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 60);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
